// File: rtl/cache_axi_bridge.sv
// Memory-side bridge of the data cache: turns cache read/write requests into AXI4
// transactions, one read and one write outstanding, with a one-line write-back buffer.
//
// state  | meaning
// R_IDLE | no read outstanding, ready for the cache
// R_AR   | read address presented, waiting for arready
// R_DATA | collecting R beats, forwarded straight to the cache
// W_IDLE | write buffer free, ready for the cache
// W_AW   | write address presented, waiting for awready
// W_DATA | streaming buffered words on W
// W_RESP | waiting for the B response
module cache_axi_bridge #(
    parameter logic [3:0] RD_ID = 4'd0,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_wdata,
    output logic         wr_rdy,
    output logic         ret_valid,
    output logic [1:0]   ret_last,
    output logic [31:0]  ret_data,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    localparam logic [2:0] TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;

    rstate_t        rstate;
    wstate_t        wstate;
    logic [127:0]   wbuf_data;
    logic [3:0]     wbuf_strb;
    logic           wbuf_line;
    logic [1:0]     cnt;
    logic           hazard;
    logic           rd_fire;
    logic           wr_fire;
    logic           rd_line;
    logic           wr_line;
    logic           unused_resp;

    assign unused_resp = ^{rresp, bresp};

    assign rd_line = (rd_type == TYPE_LINE);
    assign wr_line = (wr_type == TYPE_LINE);

    assign wr_rdy  = (wstate == W_IDLE);
    assign wr_fire = wr_req & wr_rdy;

    // awaddr holds the buffered line address for the whole write; its [31:4] is the line tag
    assign hazard = ((wstate != W_IDLE) && (rd_addr[31:4] == awaddr[31:4])) ||
                    (wr_fire && (rd_addr[31:4] == wr_addr[31:4]));
    assign rd_rdy  = (rstate == R_IDLE) & ~hazard;
    assign rd_fire = rd_req & rd_rdy;

    assign arid    = RD_ID;
    assign arburst = 2'b01;
    assign awid    = WR_ID;
    assign awburst = 2'b01;

    assign ret_valid = rready & rvalid;
    assign ret_data  = rdata;
    assign ret_last  = {1'b0, rready & rlast};

    assign wdata = wbuf_data[{cnt, 5'b00000} +: 32];
    assign wstrb = wbuf_line ? 4'hF : wbuf_strb;
    assign wlast = (cnt == awlen[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstate  <= R_IDLE;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (rd_fire) begin
                        araddr  <= rd_line ? {rd_addr[31:4], 4'h0} : rd_addr;
                        arlen   <= rd_line ? 8'd3 : 8'd0;
                        arsize  <= rd_line ? 3'd2 : {1'b0, rd_type[1:0]};
                        arvalid <= 1'b1;
                        rstate  <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rlast) begin
                        rready <= 1'b0;
                        rstate <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate    <= W_IDLE;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            awaddr    <= '0;
            awlen     <= '0;
            awsize    <= '0;
            wbuf_data <= '0;
            wbuf_strb <= '0;
            wbuf_line <= 1'b0;
            cnt       <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (wr_fire) begin
                        awaddr    <= wr_line ? {wr_addr[31:4], 4'h0} : wr_addr;
                        awlen     <= wr_line ? 8'd3 : 8'd0;
                        awsize    <= wr_line ? 3'd2 : {1'b0, wr_type[1:0]};
                        wbuf_data <= wr_wdata;
                        wbuf_strb <= wr_wstrb;
                        wbuf_line <= wr_line;
                        cnt       <= '0;
                        awvalid   <= 1'b1;
                        wstate    <= W_AW;
                    end
                end
                W_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wready) begin
                        cnt <= cnt + 2'd1;
                        if (wlast) begin
                            wvalid <= 1'b0;
                            bready <= 1'b1;
                            wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        wstate <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed-plus-random bench for cache_axi_bridge with a transaction-level model
// of expected AXI fields, beat data and handshake timing.
module tb_cache_axi_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_wdata;
    logic         wr_rdy;
    logic         ret_valid;
    logic [1:0]   ret_last;
    logic [31:0]  ret_data;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    cache_axi_bridge dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_wdata(wr_wdata), .wr_rdy(wr_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // transaction-level model state
    logic [31:0] r_addr;
    logic [2:0]  r_type;
    logic [31:0] w_addr;
    logic [2:0]  w_type;
    logic [3:0]  w_strb;
    logic [31:0] w_words [4];
    bit          w_busy = 1'b0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [2:0] t);
        return (t == 3'b100) ? (a & 32'hFFFF_FFF0) : a;
    endfunction

    function automatic int beats(input logic [2:0] t);
        return (t == 3'b100) ? 4 : 1;
    endfunction

    function automatic logic [2:0] exp_size(input logic [2:0] t);
        case (t)
            3'b000:  return 3'd0;
            3'b001:  return 3'd1;
            default: return 3'd2;
        endcase
    endfunction

    function automatic logic exp_rd_rdy();
        return !(w_busy && ((rd_addr >> 4) == (w_addr >> 4)));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [31:0] a, input logic [2:0] t);
        rd_req = 1'b1; rd_addr = a; rd_type = t;
        r_addr = a; r_type = t;
    endtask

    task automatic set_wr(input logic [31:0] a, input logic [2:0] t, input logic [3:0] s,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
        wr_req = 1'b1; wr_addr = a; wr_type = t; wr_wstrb = s;
        wr_wdata = {w3, w2, w1, w0};
        w_addr = a; w_type = t; w_strb = s;
        w_words[0] = w0; w_words[1] = w1; w_words[2] = w2; w_words[3] = w3;
    endtask

    task automatic accept(input bit exp_r, input bit exp_w);
        #1;
        if (rd_req) chk("rd_rdy_accept", rd_rdy, exp_r);
        if (wr_req) chk("wr_rdy_accept", wr_rdy, exp_w);
        step();
        rd_req = 1'b0;
        wr_req = 1'b0;
        if (exp_w) w_busy = 1'b1;
    endtask

    task automatic ar_phase();
        int d;
        chk("arvalid", arvalid, 1'b1);
        chk("araddr", araddr, exp_addr(r_addr, r_type));
        chk("arlen", arlen, (r_type == 3'b100) ? 8'd3 : 8'd0);
        chk("arsize", arsize, exp_size(r_type));
        chk("arburst", arburst, 2'b01);
        chk("arid", arid, 4'd0);
        d = $urandom_range(0, 2);
        repeat (d) begin
            step();
            chk("arvalid_hold", arvalid, 1'b1);
            chk("araddr_hold", araddr, exp_addr(r_addr, r_type));
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("arvalid_drop", arvalid, 1'b0);
        chk("rready_rise", rready, 1'b1);
    endtask

    task automatic r_phase(input logic [31:0] base, input bit fixed);
        int n;
        logic [31:0] d;
        n = beats(r_type);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            rvalid = 1'b0;
            repeat (gap) begin
                #1;
                chk("ret_valid_gap", ret_valid, 1'b0);
                chk("rready_gap", rready, 1'b1);
                step();
            end
            d = fixed ? base + 32'(i) : $urandom;
            rvalid = 1'b1; rdata = d; rlast = (i == n - 1);
            #1;
            chk("ret_valid", ret_valid, 1'b1);
            chk("ret_data", ret_data, d);
            chk("ret_last", ret_last, {1'b0, (i == n - 1)});
            step();
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("rready_done", rready, 1'b0);
        chk("ret_valid_done", ret_valid, 1'b0);
        chk("rd_rdy_done", rd_rdy, exp_rd_rdy());
    endtask

    task automatic aw_phase();
        int d;
        chk("awvalid", awvalid, 1'b1);
        chk("awaddr", awaddr, exp_addr(w_addr, w_type));
        chk("awlen", awlen, (w_type == 3'b100) ? 8'd3 : 8'd0);
        chk("awsize", awsize, exp_size(w_type));
        chk("awburst", awburst, 2'b01);
        chk("awid", awid, 4'd1);
        chk("wr_rdy_busy", wr_rdy, 1'b0);
        d = $urandom_range(0, 2);
        repeat (d) begin
            step();
            chk("awvalid_hold", awvalid, 1'b1);
            chk("wvalid_early", wvalid, 1'b0);
        end
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("awvalid_drop", awvalid, 1'b0);
        chk("wvalid_rise", wvalid, 1'b1);
    endtask

    task automatic w_phase(input logic [7:0] pat, input bit use_pat, input bit chk_hz);
        int n;
        int idx;
        int gap;
        logic wr;
        n = beats(w_type);
        idx = 0;
        for (int c = 0; c < 40 && idx < n; c++) begin
            wr = use_pat ? ((c < 8) ? pat[c] : 1'b1) : 1'($urandom_range(0, 1));
            wready = wr;
            #1;
            chk("wvalid", wvalid, 1'b1);
            chk("wdata", wdata, w_words[idx]);
            chk("wstrb", wstrb, (w_type == 3'b100) ? 4'hF : w_strb);
            chk("wlast", wlast, (idx == n - 1));
            chk("bready_early", bready, 1'b0);
            if (chk_hz) chk("rd_rdy_hazard_w", rd_rdy, exp_rd_rdy());
            step();
            if (wr) idx++;
        end
        chk("w_beats", idx, n);
        wready = 1'b0;
        #1;
        chk("wvalid_drop", wvalid, 1'b0);
        chk("bready_rise", bready, 1'b1);
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            if (chk_hz) chk("rd_rdy_hazard_b", rd_rdy, exp_rd_rdy());
            chk("wr_rdy_resp", wr_rdy, 1'b0);
            step();
            chk("bready_hold", bready, 1'b1);
        end
        bvalid = 1'b1;
        #1;
        if (chk_hz) chk("rd_rdy_at_bvalid", rd_rdy, exp_rd_rdy());
        chk("wr_rdy_at_bvalid", wr_rdy, 1'b0);
        step();
        bvalid = 1'b0;
        w_busy = 1'b0;
        #1;
        chk("bready_drop", bready, 1'b0);
        chk("wr_rdy_after_b", wr_rdy, 1'b1);
        if (chk_hz) chk("rd_rdy_after_b", rd_rdy, exp_rd_rdy());
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_arvalid"}, arvalid, 1'b0);
        chk({tag, "_awvalid"}, awvalid, 1'b0);
        chk({tag, "_wvalid"}, wvalid, 1'b0);
        chk({tag, "_rready"}, rready, 1'b0);
        chk({tag, "_bready"}, bready, 1'b0);
        chk({tag, "_ret_valid"}, ret_valid, 1'b0);
        chk({tag, "_rd_rdy"}, rd_rdy, 1'b1);
        chk({tag, "_wr_rdy"}, wr_rdy, 1'b1);
    endtask

    logic [2:0] types [4] = '{3'b000, 3'b001, 3'b010, 3'b100};

    initial begin
        rst = 1'b0;
        rd_req = 0; rd_type = 0; rd_addr = 0;
        wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_wdata = 0;
        arready = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        #3;
        chk_idle("reset");
        step();
        step();
        rst = 1'b1;
        step();
        chk_idle("post_reset");

        // line read at 0x1234, beats 0xA0..0xA3
        set_rd(32'h0000_1234, 3'b100);
        accept(1'b1, 1'b0);
        ar_phase();
        r_phase(32'hA0, 1'b1);

        // word write with partial strobes
        set_wr(32'h100, 3'b010, 4'b0011, 32'hDEADBEEF, $urandom, $urandom, $urandom);
        accept(1'b0, 1'b1);
        aw_phase();
        w_phase(8'h00, 1'b0, 1'b0);

        // line write with wready pattern 1,0,1,0,1,1
        set_wr(32'h0000_0A40, 3'b100, 4'h0, 32'h11, 32'h22, 32'h33, 32'h44);
        accept(1'b0, 1'b1);
        aw_phase();
        w_phase(8'b0011_0101, 1'b1, 1'b0);

        // hazard: write-back to line 0x2000 in flight blocks reads of that line only
        set_wr(32'h2000, 3'b100, 4'h0, $urandom, $urandom, $urandom, $urandom);
        accept(1'b0, 1'b1);
        aw_phase();
        rd_addr = 32'h2008; rd_type = 3'b100;
        #1;
        chk("hazard_block", rd_rdy, 1'b0);
        set_rd(32'h3000, 3'b010);
        accept(1'b1, 1'b0);
        ar_phase();
        r_phase(32'h0, 1'b0);
        rd_addr = 32'h2008;
        w_phase(8'h00, 1'b0, 1'b1);

        // same-cycle read and write to different lines
        set_rd(32'h4000, 3'b010);
        set_wr(32'h5000, 3'b100, 4'h0, $urandom, $urandom, $urandom, $urandom);
        accept(1'b1, 1'b1);
        chk("both_arvalid", arvalid, 1'b1);
        chk("both_awvalid", awvalid, 1'b1);
        ar_phase();
        aw_phase();
        r_phase(32'h0, 1'b0);
        w_phase(8'h00, 1'b0, 1'b0);

        // same-cycle read and write to the same line: only the write goes
        set_rd(32'h6000, 3'b100);
        set_wr(32'h6004, 3'b010, 4'hF, $urandom, 0, 0, 0);
        accept(1'b0, 1'b1);
        chk("same_line_no_ar", arvalid, 1'b0);
        aw_phase();
        w_phase(8'h00, 1'b0, 1'b0);

        // asynchronous reset with both channels mid-transfer
        set_rd(32'h7000, 3'b100);
        set_wr(32'h8000, 3'b100, 4'h0, $urandom, $urandom, $urandom, $urandom);
        accept(1'b1, 1'b1);
        ar_phase();
        aw_phase();
        rvalid = 1'b1; rdata = $urandom; rlast = 1'b0;
        #1;
        chk("pre_reset_ret_valid", ret_valid, 1'b1);
        chk("pre_reset_wvalid", wvalid, 1'b1);
        rst = 1'b0;
        #1;
        chk_idle("async_reset");
        rvalid = 1'b0;
        w_busy = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk_idle("after_release");

        // randomized traffic
        for (int it = 0; it < 16; it++) begin
            int kind;
            logic [31:0] ra;
            logic [31:0] wa;
            kind = $urandom_range(0, 2);
            ra = $urandom;
            wa = ra ^ 32'h0000_0100;
            if (kind != 1) set_rd(ra, types[$urandom_range(0, 3)]);
            if (kind != 0) set_wr(wa, types[$urandom_range(0, 3)], 4'($urandom),
                                  $urandom, $urandom, $urandom, $urandom);
            accept(kind != 1, kind != 0);
            if (kind != 1) ar_phase();
            if (kind != 0) aw_phase();
            if (kind != 1) r_phase(32'h0, 1'b0);
            if (kind != 0) w_phase(8'h00, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
